// File: rtl/bus_ctrl.sv
// -----------------------------------------------------------------------------
// bus_ctrl
//   Adapts an asynchronous-style CPU bus (chip select + read/write) to a
//   16-entry register bank. The bank sees a one-hot select, latched write
//   data and single-cycle read/write strobes. After each access the bus
//   stays quiet for RECOVERY_CYCLES cycles before a new access is accepted.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   cs         : chip select, active-high, level-sensitive
//   r_w        : 1 = read, 0 = write (sampled with cs)
//   rs         : register index 0-15
//   data       : CPU write data
//   rd_data    : read data returned by the register bank
//   data_out   : registered CPU read data
//   dtack      : registered data-transfer acknowledge
//   reg_sel    : one-hot register select to the bank
//   reg_wdata  : latched write data to the bank
//   reg_rd     : one-cycle read strobe
//   reg_wr     : one-cycle write strobe
//   dbg_state  : current FSM state (IDLE=0 SETUP=1 ACCESS=2 ACK=3 RECOVER=4)
//
// Handshake: cs is a level request held by the CPU; the access is latched on
// the first IDLE edge that sees cs=1, and dtack is the acknowledge, high for
// the whole ACK state. The CPU ends the transfer by dropping cs; dtack falls
// on the next edge. Dropping cs before ACCESS aborts with no strobe; once in
// ACCESS the strobe always fires.
// -----------------------------------------------------------------------------
module bus_ctrl #(
  parameter int unsigned RECOVERY_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        r_w,
  input  logic [3:0]  rs,
  input  logic [7:0]  data,
  input  logic [7:0]  rd_data,
  output logic [7:0]  data_out,
  output logic        dtack,
  output logic [15:0] reg_sel,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    ACK     = 3'd3,
    RECOVER = 3'd4
  } state_t;

  // Counter is loaded with N-1 and the FSM leaves RECOVER on the cycle it
  // reads 0, giving exactly N cycles in RECOVER.
  localparam logic [2:0] RC_LOAD =
    (RECOVERY_CYCLES == 0) ? 3'd0 : 3'(RECOVERY_CYCLES - 1);

  state_t     state;
  logic       rw_q;
  logic [2:0] rec_cnt;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      rec_cnt   <= 3'd0;
      data_out  <= 8'd0;
      dtack     <= 1'b0;
      reg_sel   <= 16'd0;
      reg_wdata <= 8'd0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
    end else begin
      // Strobes are single-cycle: they default low every edge.
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (cs) begin
            // Everything the access needs is captured here, so later
            // changes on rs/r_w/data cannot disturb it.
            rw_q      <= r_w;
            reg_wdata <= data;
            reg_sel   <= 16'd1 << rs;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cs) begin
            reg_rd <= rw_q;
            reg_wr <= ~rw_q;
            state  <= ACCESS;
          end else begin
            reg_sel <= 16'd0;
            state   <= IDLE;
          end
        end
        ACCESS: begin
          dtack <= 1'b1;
          if (rw_q) data_out <= rd_data;
          state <= ACK;
        end
        ACK: begin
          if (!cs) begin
            dtack   <= 1'b0;
            reg_sel <= 16'd0;
            if (RECOVERY_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              rec_cnt <= RC_LOAD;
              state   <= RECOVER;
            end
          end
        end
        RECOVER: begin
          if (rec_cnt == 3'd0) state <= IDLE;
          else                 rec_cnt <= rec_cnt - 3'd1;
        end
        default: begin
          dtack   <= 1'b0;
          reg_sel <= 16'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
module tb_bus_ctrl;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       cs = 1'b0;
  logic       r_w = 1'b0;
  logic [3:0] rs = 4'd0;
  logic [7:0] data = 8'd0;
  logic [7:0] rd_data = 8'd0;

  // DUT with 3 recovery cycles
  logic [7:0]  data_out, reg_wdata;
  logic        dtack, reg_rd, reg_wr;
  logic [15:0] reg_sel;
  logic [2:0]  dbg_state;

  // DUT with no recovery
  logic [7:0]  data_out0, reg_wdata0;
  logic        dtack0, reg_rd0, reg_wr0;
  logic [15:0] reg_sel0;
  logic [2:0]  dbg_state0;

  bus_ctrl #(.RECOVERY_CYCLES(3)) u_dut (
    .clk(clk), .reset(reset), .cs(cs), .r_w(r_w), .rs(rs), .data(data),
    .rd_data(rd_data), .data_out(data_out), .dtack(dtack), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .dbg_state(dbg_state)
  );

  bus_ctrl #(.RECOVERY_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .cs(cs), .r_w(r_w), .rs(rs), .data(data),
    .rd_data(rd_data), .data_out(data_out0), .dtack(dtack0), .reg_sel(reg_sel0),
    .reg_wdata(reg_wdata0), .reg_rd(reg_rd0), .reg_wr(reg_wr0),
    .dbg_state(dbg_state0)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare data_out with the oldest outstanding read expectation.
  task automatic check_read(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, data_out}, {24'd0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic rw, input logic [3:0] a,
                       input logic [7:0] d);
    cs   = c;
    r_w  = rw;
    rs   = a;
    data = d;
  endtask

  // Drop cs while in ACK and count cycles spent in RECOVER (bounded).
  task automatic finish_access(input string tag, input int exp_rec);
    int n;
    n = 0;
    cs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dbg_state == S_RECOVER) n++;
      else if (dbg_state == S_IDLE) break;
    end
    check({tag, "_rec_cycles"}, n, exp_rec);
    check({tag, "_idle"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;

    // Reset state
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    repeat (3) tick();
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("rst_outs", {dtack, reg_rd, reg_wr, reg_sel, reg_wdata, data_out},
          32'd0);
    reset = 1'b0;
    tick();

    // Read: rs=1, rd_data=A5
    rd_data = 8'hA5;
    drive(1'b1, 1'b1, 4'h1, 8'h00);
    exp_q.push_back(8'hA5);
    tick();                                   // edge k
    check("rd_setup", {29'd0, dbg_state}, {29'd0, S_SETUP});
    check("rd_sel", {16'd0, reg_sel}, 32'h0002);
    check("rd_nostrobe_k", {30'd0, reg_rd, reg_wr}, 32'd0);
    drive(1'b1, 1'b0, 4'h7, 8'hFF);           // changes after latch are ignored
    tick();                                   // edge k+1
    check("rd_strobe", {30'd0, reg_rd, reg_wr}, 32'b10);
    check("rd_sel_access", {16'd0, reg_sel}, 32'h0002);
    check("rd_dtack_early", {31'd0, dtack}, 32'd0);
    tick();                                   // edge k+2
    check("rd_dtack", {31'd0, dtack}, 32'd1);
    check("rd_strobe_end", {30'd0, reg_rd, reg_wr}, 32'd0);
    check_read("rd_data");
    check("rd_dtack_nr", {31'd0, dtack0}, 32'd1);
    rd_data = 8'h11;
    repeat (2) tick();                        // cs held: stay in ACK
    check("rd_ack_hold", {29'd0, dbg_state}, {29'd0, S_ACK});
    check("rd_no_second", {30'd0, reg_rd, reg_wr}, 32'd0);
    check("rd_data_hold", {24'd0, data_out}, 32'h00A5);
    cs = 1'b0;
    tick();
    check("rd_rec_enter", {29'd0, dbg_state}, {29'd0, S_RECOVER});
    check("rd_rec_outs", {15'd0, dtack, reg_sel}, 32'd0);
    check("nr_ack_to_idle", {29'd0, dbg_state0}, {29'd0, S_IDLE});
    check("nr_dtack_low", {31'd0, dtack0}, 32'd0);
    repeat (2) tick();
    check("rd_rec_still", {29'd0, dbg_state}, {29'd0, S_RECOVER});
    tick();
    check("rd_rec_done", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // Write: rs=3, data=5C, data_out must stay A5
    rd_data = 8'h33;
    drive(1'b1, 1'b0, 4'h3, 8'h5C);
    tick();
    check("wr_wdata", {24'd0, reg_wdata}, 32'h005C);
    check("wr_sel", {16'd0, reg_sel}, 32'h0008);
    data = 8'h99;
    tick();
    check("wr_strobe", {30'd0, reg_rd, reg_wr}, 32'b01);
    tick();
    check("wr_dtack", {31'd0, dtack}, 32'd1);
    check("wr_data_out", {24'd0, data_out}, 32'h00A5);
    check("wr_wdata_hold", {24'd0, reg_wdata}, 32'h005C);
    finish_access("wr", 3);

    // Abort: cs high for one sample only
    drive(1'b1, 1'b1, 4'h6, 8'h00);
    tick();
    check("ab_setup", {29'd0, dbg_state}, {29'd0, S_SETUP});
    cs = 1'b0;
    tick();
    check("ab_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("ab_outs", {13'd0, dtack, reg_rd, reg_wr, reg_sel}, 32'd0);
    tick();
    check("ab_quiet", {29'd0, dtack, reg_rd, reg_wr}, 32'd0);

    // Back-to-back: cs re-raised during RECOVER
    rd_data = 8'hC3;
    drive(1'b1, 1'b1, 4'h5, 8'h00);
    exp_q.push_back(8'hC3);
    repeat (3) tick();
    check_read("bb1_data");
    cs = 1'b0;
    tick();                                   // RECOVER, count 2
    drive(1'b1, 1'b1, 4'h9, 8'h00);
    rd_data = 8'h3C;
    exp_q.push_back(8'h3C);
    repeat (2) tick();
    check("bb_rec_ignore", {29'd0, dbg_state}, {29'd0, S_RECOVER});
    check("bb_rec_sel", {16'd0, reg_sel}, 32'd0);
    tick();
    check("bb_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    tick();
    check("bb_sel2", {16'd0, reg_sel}, 32'h0200);
    repeat (2) tick();
    check("bb2_dtack", {31'd0, dtack}, 32'd1);
    check_read("bb2_data");
    finish_access("bb2", 3);

    // Reset mid-ACCESS with cs held
    drive(1'b1, 1'b1, 4'h2, 8'h00);
    rd_data = 8'h77;
    repeat (2) tick();
    check("rs_access", {31'd0, reg_rd}, 32'd1);
    reset = 1'b1;
    #1;
    check("rs_async", {dtack, reg_rd, reg_wr, reg_sel, reg_wdata, data_out},
          32'd0);
    check("rs_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    tick();
    reset = 1'b0;
    exp_q.push_back(8'h77);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (dtack) break;
    end
    check("rs_latency", lat, 3);
    check_read("rs_data");
    finish_access("rs", 3);

    // Sweep rs 0..15 (writes)
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 8'($urandom_range(0, 255)));
      tick();
      check($sformatf("sw_sel%0d", i), {16'd0, reg_sel}, 32'd1 << i);
      check($sformatf("sw_onehot%0d", i), {31'd0, $onehot(reg_sel)}, 32'd1);
      repeat (2) tick();
      finish_access($sformatf("sw%0d", i), 3);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Strobes must never be high together.
  always @(negedge clk) begin
    if (!reset && reg_rd && reg_wr) check("rd_wr_both", 32'd1, 32'd0);
  end

endmodule
